// File: rtl/wb_clint_slave.sv
// -----------------------------------------------------------------------------
// wb_clint_slave
//
// Wishbone classic slave implementing the core-local interruptor (CLINT):
// a free-running 64-bit machine timer (mtime), its compare register
// (mtimecmp) and the machine software interrupt bit (msip). The block drives
// the core's interrupt_clint / exception_code_clint inputs, gated by the
// core's forwarded mie / mstatus values.
//
// Register map (byte offsets, address bits [1:0] ignored):
//   0x0000 msip (bit0)    0x4000/0x4004 mtimecmp lo/hi
//   0xBFF8/0xBFFC mtime lo/hi
//   Any other offset is acknowledged, reads 0 and discards writes.
//
// Parameters:
//   ADDR_LSB_W  number of low address bits decoded (upper bits ignored)
//   TICK_DIV    clk cycles per mtime increment, 1..65535
//
// Build option:
//   CLINT_WAIT_STATE_EN  when defined, the bus FSM inserts a WAIT state
//                        (IDLE -> WAIT -> ACK), giving 2-cycle latency.
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   asynchronous active-low reset
//   wb_adr_i/wb_dat_i     byte address / write data
//   wb_we_i/wb_sel_i      write enable / byte-lane selects
//   wb_stb_i/wb_cyc_i     strobe / cycle valid
//   wb_dat_o/wb_ack_o     read data (valid with ack) / one-cycle acknowledge
//   latest_mie            forwarded mie (bit3 MSIE, bit7 MTIE)
//   latest_mstatus        forwarded mstatus (bit3 MIE)
//   interrupt_clint       registered interrupt request
//   exception_code_clint  cause: 3 software, 7 timer, 0 none
// -----------------------------------------------------------------------------
module wb_clint_slave #(
    parameter int ADDR_LSB_W = 16,
    parameter int TICK_DIV   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic [31:0] latest_mie,
    input  logic [31:0] latest_mstatus,
    output logic        interrupt_clint,
    output logic [30:0] exception_code_clint
);

    // Bus FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Decoded register offsets (word aligned)
    localparam logic [ADDR_LSB_W-1:0] OFF_MSIP     = ADDR_LSB_W'(32'h0000_0000);
    localparam logic [ADDR_LSB_W-1:0] OFF_MTCMP_LO = ADDR_LSB_W'(32'h0000_4000);
    localparam logic [ADDR_LSB_W-1:0] OFF_MTCMP_HI = ADDR_LSB_W'(32'h0000_4004);
    localparam logic [ADDR_LSB_W-1:0] OFF_MTIME_LO = ADDR_LSB_W'(32'h0000_BFF8);
    localparam logic [ADDR_LSB_W-1:0] OFF_MTIME_HI = ADDR_LSB_W'(32'h0000_BFFC);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    // Replace the selected byte lanes of a 32-bit word with new data.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Flops
    logic [1:0]  state_q,    state_d;
    logic        ack_q,      ack_d;
    logic [31:0] dat_q,      dat_d;
    logic        msip_q,     msip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime_q,    mtime_d;
    logic [15:0] presc_q,    presc_d;
    logic        irq_q,      irq_d;
    logic [30:0] code_q,     code_d;

    // Combinational helpers
    logic                  access_go_s;
    logic                  wr_s;
    logic                  rd_s;
    logic [ADDR_LSB_W-1:0] adr_s;
    logic                  hit_msip_s;
    logic                  hit_cmp_lo_s;
    logic                  hit_cmp_hi_s;
    logic                  hit_mt_lo_s;
    logic                  hit_mt_hi_s;
    logic                  presc_wrap_s;
    logic [31:0]           rdata_s;
    logic                  sw_req_s;
    logic                  tm_req_s;
    logic                  unused_s;

    // Word-aligned offset: byte-address bits [1:0] are ignored.
    assign adr_s        = {wb_adr_i[ADDR_LSB_W-1:2], 2'b00};
    assign hit_msip_s   = (adr_s == OFF_MSIP);
    assign hit_cmp_lo_s = (adr_s == OFF_MTCMP_LO);
    assign hit_cmp_hi_s = (adr_s == OFF_MTCMP_HI);
    assign hit_mt_lo_s  = (adr_s == OFF_MTIME_LO);
    assign hit_mt_hi_s  = (adr_s == OFF_MTIME_HI);

    // Bits that carry no meaning for this slave.
    assign unused_s = ^{wb_adr_i[31:ADDR_LSB_W], wb_adr_i[1:0],
                        latest_mie[31:8], latest_mie[6:4], latest_mie[2:0],
                        latest_mstatus[31:4], latest_mstatus[2:0]};

    // Bus FSM next state; access_go_s marks the edge that enters ACK, where
    // the write is committed and read data is sampled.
    always_comb begin
        state_d     = state_q;
        access_go_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
`ifdef CLINT_WAIT_STATE_EN
                    state_d = ST_WAIT;
`else
                    state_d     = ST_ACK;
                    access_go_s = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A master that abandons the cycle during the wait state
                // gets no ack and nothing is committed.
                if (wb_cyc_i && wb_stb_i) begin
                    state_d     = ST_ACK;
                    access_go_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                // Always leave ACK; a strobe held high here is not a new access.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wr_s = access_go_s & wb_we_i;
    assign rd_s = access_go_s & ~wb_we_i;

    // Read data multiplexer; unmapped offsets read zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (hit_msip_s) begin
            rdata_s = {31'h0000_0000, msip_q};
        end else if (hit_cmp_lo_s) begin
            rdata_s = mtimecmp_q[31:0];
        end else if (hit_cmp_hi_s) begin
            rdata_s = mtimecmp_q[63:32];
        end else if (hit_mt_lo_s) begin
            rdata_s = mtime_q[31:0];
        end else if (hit_mt_hi_s) begin
            rdata_s = mtime_q[63:32];
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Bus response: ack follows the ACK state, data is held only during ACK.
    always_comb begin
        ack_d = (state_d == ST_ACK);
        if (rd_s) begin
            dat_d = rdata_s;
        end else begin
            dat_d = 32'h0000_0000;
        end
    end

    // msip and mtimecmp write path.
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_s && hit_msip_s && wb_sel_i[0]) begin
            msip_d = wb_dat_i[0];
        end else begin
            msip_d = msip_q;
        end
        if (wr_s && hit_cmp_lo_s) begin
            mtimecmp_d[31:0] = merge_lanes(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
        end else if (wr_s && hit_cmp_hi_s) begin
            mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
    end

    // Prescaler and mtime: a bus write to either mtime word wins over the
    // tick for that cycle, while the prescaler keeps its own cadence.
    always_comb begin
        presc_wrap_s = (presc_q == PRESC_LAST);
        if (presc_wrap_s) begin
            presc_d = 16'h0000;
        end else begin
            presc_d = presc_q + 16'h0001;
        end
        if (wr_s && hit_mt_lo_s) begin
            mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
        end else if (wr_s && hit_mt_hi_s) begin
            mtime_d = {merge_lanes(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
        end else if (presc_wrap_s) begin
            // Full 64-bit add: carry into the high word lands in the same cycle.
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
    end

    // Interrupt request and cause, software has priority over timer.
    always_comb begin
        sw_req_s = msip_q & latest_mie[3] & latest_mstatus[3];
        tm_req_s = (mtime_q >= mtimecmp_q) & latest_mie[7] & latest_mstatus[3];
        irq_d    = sw_req_s | tm_req_s;
        if (sw_req_s) begin
            code_d = 31'd3;
        end else if (tm_req_s) begin
            code_d = 31'd7;
        end else begin
            code_d = 31'd0;
        end
    end

    // Bus FSM and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    // CLINT architectural registers and prescaler.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip_q     <= 1'b0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime_q    <= 64'h0000_0000_0000_0000;
            presc_q    <= 16'h0000;
        end else begin
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            mtime_q    <= mtime_d;
            presc_q    <= presc_d;
        end
    end

    // Registered interrupt outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q  <= 1'b0;
            code_q <= 31'd0;
        end else begin
            irq_q  <= irq_d;
            code_q <= code_d;
        end
    end

    assign wb_ack_o             = ack_q;
    assign wb_dat_o             = dat_q;
    assign interrupt_clint      = irq_q;
    assign exception_code_clint = code_q;

endmodule
